// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU control codes, register-zero index and ID/EX slot state encoding.
`default_nettype none

package mips_pkg;

  localparam int IMM_W   = 16;
  localparam int SHAMT_W = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_ADDU = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SUB  = 4'd6,
    ALU_SLTU = 4'd7
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_BUBBLE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fwd_unit.sv
// fwd_unit: combinational operand bypass, EX/MEM over MEM/WB over register-file data.
`default_nettype none

module fwd_unit
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              exmem_we_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_res_i,
  input  logic              memwb_we_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_res_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = reg_data_i;
    // r0 is hardwired zero, so a producer targeting it must never bypass.
    if (src_i != REG_AW'(REG_ZERO)) begin
      if (exmem_we_i && (exmem_rd_i == src_i)) begin
        data_o = exmem_res_i;
      end else if (memwb_we_i && (memwb_rd_i == src_i)) begin
        data_o = memwb_res_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with immediate extension, operand forwarding and load-use bubble.
// Build macro FWD_EN enables forwarding and load-use detection; without it hazards are left to software.
`default_nettype none

module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [15:0]       id_imm,
  input  logic              id_use_imm,
  input  logic              id_sign_ext,
  input  logic [4:0]        id_shamt,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              ex_stall,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [4:0]        ex_shamt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_is_load,
  output logic              load_use_stall
);

  state_e              state_q, state_d;
  logic                capture;
  logic                load_use;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [REG_AW-1:0]   rs_q, rt_q, rd_q;
  logic [DATA_W-1:0]   rs_data_q, rt_data_q, imm_ext_q;
  logic                use_imm_q, reg_write_q, is_load_q;
  logic [4:0]          shamt_q;
  logic [DATA_W-1:0]   imm_ext;
  logic [DATA_W-1:0]   fwd_a, fwd_b;

  assign imm_ext = {{(DATA_W-16){id_imm[15] & id_sign_ext}}, id_imm};

  assign ex_valid = (state_q == ST_FULL);

`ifdef FWD_EN
  assign load_use = ex_valid & is_load_q & (rd_q != REG_AW'(REG_ZERO)) &
                    ((rd_q == id_rs) | ((rd_q == id_rt) & ~id_use_imm));

  fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .src_i      (rs_q),
    .reg_data_i (rs_data_q),
    .exmem_we_i (exmem_reg_write),
    .exmem_rd_i (exmem_rd),
    .exmem_res_i(exmem_result),
    .memwb_we_i (memwb_reg_write),
    .memwb_rd_i (memwb_rd),
    .memwb_res_i(memwb_result),
    .data_o     (fwd_a)
  );

  fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .src_i      (rt_q),
    .reg_data_i (rt_data_q),
    .exmem_we_i (exmem_reg_write),
    .exmem_rd_i (exmem_rd),
    .exmem_res_i(exmem_result),
    .memwb_we_i (memwb_reg_write),
    .memwb_rd_i (memwb_rd),
    .memwb_res_i(memwb_result),
    .data_o     (fwd_b)
  );
`else
  logic unused_fwd;
  assign load_use   = 1'b0;
  assign fwd_a      = rs_data_q;
  assign fwd_b      = rt_data_q;
  assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result, rs_q, rt_q};
`endif

  assign id_ready       = ~rst & ~ex_stall & ~load_use;
  assign load_use_stall = load_use & id_valid & ~ex_stall;

  assign ex_ctrl      = ctrl_q;
  assign ex_a         = fwd_a;
  assign ex_b         = use_imm_q ? imm_ext_q : fwd_b;
  assign ex_shamt     = shamt_q;
  assign ex_rd        = rd_q;
  assign ex_reg_write = reg_write_q & ex_valid;
  assign ex_is_load   = is_load_q & ex_valid;

  // Flush beats stall beats bubble beats capture.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (ex_stall) begin
      state_d = state_q;
    end else if (load_use_stall) begin
      state_d = ST_BUBBLE;
    end else if (id_valid && id_ready) begin
      state_d = ST_FULL;
      capture = 1'b1;
    end else begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      ctrl_q      <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_ext_q   <= '0;
      use_imm_q   <= 1'b0;
      shamt_q     <= '0;
      reg_write_q <= 1'b0;
      is_load_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        ctrl_q      <= id_ctrl;
        rs_q        <= id_rs;
        rt_q        <= id_rt;
        rd_q        <= id_rd;
        rs_data_q   <= id_rs_data;
        rt_data_q   <= id_rt_data;
        imm_ext_q   <= imm_ext;
        use_imm_q   <= id_use_imm;
        shamt_q     <= id_shamt;
        reg_write_q <= id_reg_write;
        is_load_q   <= id_is_load;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven vectors through a scoreboard queue plus hazard/stall/flush/reset sequences.
`timescale 1ns/1ps
`default_nettype none

module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clk, rst;
  logic        id_valid, id_ready;
  logic [3:0]  id_ctrl;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic        id_use_imm, id_sign_ext;
  logic [4:0]  id_shamt;
  logic        id_reg_write, id_is_load;
  logic        flush, ex_stall;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        ex_valid;
  logic [3:0]  ex_ctrl;
  logic [31:0] ex_a, ex_b;
  logic [4:0]  ex_shamt, ex_rd;
  logic        ex_reg_write, ex_is_load, load_use_stall;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_sign_ext(id_sign_ext),
    .id_shamt(id_shamt), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .flush(flush), .ex_stall(ex_stall),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b),
    .ex_shamt(ex_shamt), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_is_load(ex_is_load), .load_use_stall(load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd;
    logic [15:0] imm;
    logic        ui, sx;
    logic [4:0]  sh;
    logic        rw, ld;
    logic        xw;
    logic [4:0]  xrd;
    logic [31:0] xres;
    logic        mw;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic [31:0] ea, eb;
  } vec_t;

  typedef struct packed {
    logic        v;
    logic [3:0]  ctrl;
    logic [31:0] a, b;
    logic [4:0]  sh, rd;
    logic        rw, ld;
  } out_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  out_t sb_q[$];
  vec_t tbl[10];

  function automatic logic [31:0] m_fwd(input logic [4:0] src, input logic [31:0] rdata,
                                        input logic xw, input logic [4:0] xrd, input logic [31:0] xres,
                                        input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
`ifdef FWD_EN
    if (src == 5'd0) return rdata;
    if (xw && xrd == src) return xres;
    if (mw && mrd == src) return mres;
`endif
    return rdata;
  endfunction

  function automatic logic [31:0] m_ext(input logic [15:0] imm, input logic sx);
    logic [31:0] r;
    r = {16'h0000, imm};
    if (sx && imm[15]) r[31:16] = 16'hFFFF;
    return r;
  endfunction

  function automatic vec_t mk(input logic [3:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                              input logic [15:0] imm, input logic ui, input logic sx, input logic [4:0] sh,
                              input logic rw, input logic ld, input logic xw, input logic [4:0] xrd,
                              input logic [31:0] xres, input logic mw, input logic [4:0] mrd,
                              input logic [31:0] mres);
    vec_t v;
    v.ctrl = ctrl; v.rs = rs; v.rt = rt; v.rd = rd; v.rsd = rsd; v.rtd = rtd;
    v.imm = imm; v.ui = ui; v.sx = sx; v.sh = sh; v.rw = rw; v.ld = ld;
    v.xw = xw; v.xrd = xrd; v.xres = xres; v.mw = mw; v.mrd = mrd; v.mres = mres;
    v.ea = m_fwd(rs, rsd, xw, xrd, xres, mw, mrd, mres);
    v.eb = ui ? m_ext(imm, sx) : m_fwd(rt, rtd, xw, xrd, xres, mw, mrd, mres);
    return v;
  endfunction

  function automatic out_t dut_out();
    return {ex_valid, ex_ctrl, ex_a, ex_b, ex_shamt, ex_rd, ex_reg_write, ex_is_load};
  endfunction

  task automatic chk(input string nm, input logic [80:0] act, input logic [80:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_ctrl = v.ctrl; id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    id_rs_data = v.rsd; id_rt_data = v.rtd; id_imm = v.imm;
    id_use_imm = v.ui; id_sign_ext = v.sx; id_shamt = v.sh;
    id_reg_write = v.rw; id_is_load = v.ld;
    exmem_reg_write = v.xw; exmem_rd = v.xrd; exmem_result = v.xres;
    memwb_reg_write = v.mw; memwb_rd = v.mrd; memwb_result = v.mres;
  endtask

  task automatic apply_row(input string nm, input vec_t v);
    out_t e;
    @(negedge clk);
    drive(v);
    id_valid = 1'b1;
    sb_q.push_back('{v: 1'b1, ctrl: v.ctrl, a: v.ea, b: v.eb, sh: v.sh, rd: v.rd, rw: v.rw, ld: v.ld});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({nm, "_sb_empty"}, 81'd0, 81'd1);
    end else begin
      e = sb_q.pop_front();
      chk(nm, dut_out(), e);
    end
  endtask

  out_t e_s;
  vec_t v_tmp;

  initial begin
    rst = 1'b1; id_valid = 1'b0; flush = 1'b0; ex_stall = 1'b0;
    drive(mk(4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0,
             1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0));

    tbl[0] = mk(ALU_ADD,  5'd1, 5'd2, 5'd3,  32'd5,  32'd7,  16'h0000, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0);
    tbl[1] = mk(ALU_ADD,  5'd1, 5'd2, 5'd3,  32'd5,  32'd7,  16'h0000, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 5'd1, 32'd9,         1'b1, 5'd1, 32'd3);
    tbl[2] = mk(ALU_ADD,  5'd1, 5'd2, 5'd3,  32'd5,  32'd7,  16'h0000, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 5'd0, 32'd9,         1'b1, 5'd1, 32'd3);
    tbl[3] = mk(ALU_ADDU, 5'd1, 5'd2, 5'd8,  32'd5,  32'd7,  16'hFFFE, 1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0);
    tbl[4] = mk(ALU_ADDU, 5'd1, 5'd2, 5'd8,  32'd5,  32'd7,  16'hFFFE, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0);
    tbl[5] = mk(ALU_OR,   5'd0, 5'd3, 5'd9,  32'h11, 32'h22, 16'h0000, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 5'd0, 32'hDEAD,      1'b1, 5'd3, 32'h44);
    tbl[6] = mk(ALU_AND,  5'd4, 5'd6, 5'd10, 32'h1,  32'h2,  16'h1234, 1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b1, 5'd6, 32'hBEEF,      1'b0, 5'd0, 32'd0);
    tbl[7] = mk(ALU_SLL,  5'd0, 5'd2, 5'd31, 32'h0,  32'h3,  16'h0000, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0);
    tbl[8] = mk(ALU_ADD,  5'd5, 5'd6, 5'd0,  32'h50, 32'h60, 16'h0010, 1'b1, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0);
    tbl[9] = mk(ALU_SLTU, 5'd7, 5'd8, 5'd12, 32'h70, 32'h80, 16'h0000, 1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 1'b1, 5'd8, 32'h81,        1'b1, 5'd7, 32'h71);

    #2;
    chk("reset_out", dut_out(), 81'd0);
    chk("reset_ready", {80'd0, id_ready}, 81'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {80'd0, id_ready}, 81'd1);

    for (int i = 0; i < 10; i++) apply_row($sformatf("row%0d", i), tbl[i]);

    // Load to r4 followed by a consumer of r4.
    apply_row("lu_load", mk(ALU_ADD, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 16'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1,
                            1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0));
    @(negedge clk);
    v_tmp = mk(ALU_SUB, 5'd4, 5'd2, 5'd5, 32'h40, 32'd7, 16'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0,
               1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive(v_tmp);
    #1;
`ifdef FWD_EN
    chk("lu_stall_on", {79'd0, load_use_stall, id_ready}, 81'b10);
    @(posedge clk); #1;
    chk("lu_bubble", {78'd0, ex_valid, ex_reg_write, ex_is_load}, 81'd0);
    chk("lu_stall_off", {79'd0, load_use_stall, id_ready}, 81'b01);
    @(posedge clk); #1;
`else
    chk("lu_stall_on", {79'd0, load_use_stall, id_ready}, 81'b01);
    @(posedge clk); #1;
`endif
    chk("lu_capture", dut_out(), out_t'{v: 1'b1, ctrl: ALU_SUB, a: 32'h40, b: 32'd7, sh: 5'd0,
                                        rd: 5'd5, rw: 1'b1, ld: 1'b0});

    // A load whose rd only matches an rt that is replaced by the immediate causes no stall.
    apply_row("lu2_load", mk(ALU_ADD, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 16'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1,
                             1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0));
    @(negedge clk);
    drive(mk(ALU_ADD, 5'd0, 5'd5, 5'd6, 32'd0, 32'd0, 16'h0003, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0,
             1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0));
    #1;
    chk("lu_imm_nostall", {79'd0, load_use_stall, id_ready}, 81'b01);
    @(posedge clk); #1;
    chk("lu_imm_capture", {77'd0, ex_valid, ex_rd}, {77'd0, 1'b1, 5'd6});

    // Stall holds EX while forwarding still tracks the bypass inputs.
    apply_row("stall_cap", mk(ALU_ADD, 5'd3, 5'd9, 5'd7, 32'h33, 32'h99, 16'h0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0,
                              1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0));
    e_s = '{v: 1'b1, ctrl: ALU_ADD, a: 32'h33, b: 32'h99, sh: 5'd2, rd: 5'd7, rw: 1'b1, ld: 1'b0};
    @(negedge clk);
    drive(mk(ALU_OR, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2, 16'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0,
             1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0));
    ex_stall = 1'b1;
    #1;
    chk("stall_ready", {79'd0, load_use_stall, id_ready}, 81'd0);
    @(posedge clk); #1;
    chk("stall_hold", dut_out(), e_s);
    exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'hABC;
    #1;
    chk("stall_fwd_a", {49'd0, ex_a}, {49'd0, m_fwd(5'd3, 32'h33, 1'b1, 5'd3, 32'hABC, 1'b0, 5'd0, 32'd0)});
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_stall", {79'd0, ex_valid, ex_reg_write}, 81'd0);
    @(negedge clk);
    flush = 1'b0; ex_stall = 1'b0;

    // Idle ID empties a full slot.
    apply_row("idle_cap", tbl[0]);
    @(negedge clk);
    id_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_empty", {78'd0, ex_valid, ex_reg_write, ex_is_load}, 81'd0);

    // Asynchronous reset while full.
    apply_row("rst_cap", tbl[7]);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_out", dut_out(), 81'd0);
    chk("rst_async_ready", {80'd0, id_ready}, 81'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
